// File: rtl/fp_to_fixed_pkg.sv
// Shared IEEE-754 single-precision field definitions for the gain/mix path
// (fpmult and fp_to_fixed).
package fp_to_fixed_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_MAX  = 255;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_HI   = 30;
  localparam int FP_EXP_LO   = 23;
  localparam int FP_FRAC_HI  = 22;
  localparam int FP_MANT_W   = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_to_fixed.sv
// IEEE single to signed fixed-point PCM converter: iterative 1-bit-per-cycle
// shifter, round half away from zero, saturating, start/busy/done handshake.
module fp_to_fixed
  import fp_to_fixed_pkg::*;
#(
  parameter int OUT_WIDTH = 24,
  parameter int SCALE_EXP = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          dataa,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 sat
);

  localparam int SRW = max_int(OUT_WIDTH, FP_MANT_W) + 1;

  localparam logic signed [9:0] BIAS10    = 10'(FP_EXP_BIAS);
  localparam logic signed [9:0] SCALE10   = 10'(SCALE_EXP);
  localparam logic signed [9:0] OVF10     = 10'(OUT_WIDTH - 1);
  localparam logic signed [9:0] MANT_LSB  = 10'(FP_MANT_W - 1);
  localparam logic signed [9:0] NEG_ONE   = -10'sd1;

  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [SRW-1:0]       MAX_MAG = SRW'(POS_MAX);

  typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, ROUND} state_t;

  state_t                state;
  logic                  sign_q;
  logic [7:0]            exp_q;
  logic [FP_MANT_W-1:0]  mant_q;
  logic [SRW-1:0]        sr;
  logic [5:0]            cnt;
  logic                  dir_left;

  logic signed [9:0]     e_val;
  logic                  is_special;
  logic [OUT_WIDTH-1:0]  special_result;
  logic                  special_sat;
  logic [SRW-1:0]        mag;

  // Unbiased, scaled exponent and the early-exit classification of the latched sample
  always_comb begin
    e_val          = signed'({2'b00, exp_q}) - BIAS10 + SCALE10;
    is_special     = 1'b1;
    special_result = '0;
    special_sat    = 1'b0;
    if (exp_q == 8'd0) begin
      special_sat = 1'b0;
    end else if (exp_q == 8'(FP_EXP_MAX) && mant_q[FP_FRAC_HI:0] != '0) begin
      special_sat = 1'b1;
    end else if (exp_q == 8'(FP_EXP_MAX) || e_val >= OVF10) begin
      special_result = sign_q ? NEG_MIN : POS_MAX;
      special_sat    = 1'b1;
    end else if (e_val < NEG_ONE) begin
      special_sat = 1'b0;
    end else begin
      is_special = 1'b0;
    end
    mag = (sr >> 1) + SRW'(sr[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat      <= 1'b0;
      result   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sr       <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= dataa[FP_SIGN_BIT];
            exp_q  <= dataa[FP_EXP_HI:FP_EXP_LO];
            mant_q <= {1'b1, dataa[FP_FRAC_HI:0]};
            busy   <= 1'b1;
            state  <= UNPACK;
          end
        end
        UNPACK: begin
          if (is_special) begin
            result <= special_result;
            sat    <= special_sat;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            // Guard bit starts clear; the mantissa sits just above it
            sr       <= SRW'({mant_q, 1'b0});
            cnt      <= 6'((e_val < MANT_LSB) ? (MANT_LSB - e_val) : (e_val - MANT_LSB));
            dir_left <= (e_val > MANT_LSB);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == 6'd0) begin
            state <= ROUND;
          end else begin
            sr  <= dir_left ? (sr << 1) : (sr >> 1);
            cnt <= cnt - 6'd1;
          end
        end
        ROUND: begin
          // A negative magnitude of exactly 2^(OUT_WIDTH-1) is representable
          if (sign_q) begin
            result <= -mag[OUT_WIDTH-1:0];
            sat    <= 1'b0;
          end else if (mag > MAX_MAG) begin
            result <= POS_MAX;
            sat    <= 1'b1;
          end else begin
            result <= mag[OUT_WIDTH-1:0];
            sat    <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
